vga_pixel_fetch: RTL
====================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning fixed framebuffer read latency in cycles (legal range 1..4).
REQ-002 SHALL have parameter FB_W, default 320, meaning framebuffer width in pixels.
REQ-003 SHALL have parameter FB_H, default 256, meaning framebuffer height in lines.
REQ-004 SHALL have parameter COLOR_W, default 12, meaning RGB 4:4:4 pixel width.
REQ-005 SHALL have port pixel_clk_i, input, 1 bit: pixel clock (108 MHz); one clock only; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports h_count_i and v_count_i, input, 11 bits each: line and frame counters from the sync generator.
REQ-008 SHALL have ports h_sync_i, v_sync_i and active_i, input, 1 bit each: active-high syncs and display-region flag.
REQ-009 SHALL have port rd_req_o, output, 1 bit: framebuffer read strobe.
REQ-010 SHALL have port rd_addr_o, output, 17 bits: framebuffer word address.
REQ-011 SHALL have port rd_data_i, input, COLOR_W bits: read data, valid exactly RD_LAT cycles after rd_req_o.
REQ-012 SHALL have ports rgb_o (output, COLOR_W bits), h_sync_o, v_sync_o and active_o (output, 1 bit each): aligned pixel output to the DAC.
REQ-013 SHALL have port frame_start_o, output, 1 bit: one-cycle pulse aligned with output pixel (0,0).

Function
REQ-014 SHALL register h_count_i, v_count_i, h_sync_i, v_sync_i and active_i every cycle (stage S0).
REQ-015 SHALL compute the address from S0 as (v>>2)*FB_W + (h>>2) using shift-add only (no multiplier) and register it onto rd_addr_o in S1.
REQ-016 SHALL assert rd_req_o in S1 only when the S0 active flag is 1 and (v>>2) < FB_H; otherwise rd_req_o = 0 and rd_addr_o holds its previous value.
REQ-017 SHALL capture rd_data_i RD_LAT cycles after the matching rd_req_o and register it onto rgb_o, giving a total input-to-output latency L = RD_LAT+2 cycles.
REQ-018 SHALL delay h_sync, v_sync and active by exactly L cycles so they align with rgb_o.
REQ-019 SHALL drive rgb_o = 0 in any output cycle whose aligned active flag is 0 or whose aligned request flag is 0; rd_data_i is ignored in those cycles.
REQ-020 SHALL pulse frame_start_o for one cycle when the aligned counters equal h=0, v=0 and active=1.
REQ-021 SHALL compute addresses with no carry loss: the maximum address is 81919 at (1279,1023) and fits in 17 bits; counter values of 1280..1687 and 1024..1065 never produce a read.
REQ-022 SHALL tolerate a counter wrap from (1687,1065) to (0,0) with no bubble; pixel (0,0) of the new frame is requested in the cycle after the last blank.
REQ-023 SHALL NOT add a handshake beyond fixed latency; back-pressure is unsupported.

Reset
REQ-024 SHALL, while rst_ni = 0, asynchronously clear all pipeline registers and drive rgb_o, rd_req_o, rd_addr_o, h_sync_o, v_sync_o, active_o and frame_start_o to 0.
REQ-025 SHALL, after a reset asserted mid-line, keep outputs at 0 until the first post-reset input has propagated L cycles; read data in flight before reset SHALL be discarded.

Configuration
REQ-026 SHALL use the macro VGA_TEST_PATTERN_EN: when defined, an extra input port test_mode_i (1 bit) is present; when it is 1, rgb_o in active cycles is replaced by an 8-bar colour pattern indexed by output h>>7 (bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black), with identical latency and no reads issued.
REQ-027 SHALL, when VGA_TEST_PATTERN_EN is undefined, omit the port and the pattern logic, leaving behaviour per REQ-014..REQ-023.

Structure
REQ-028 SHALL take timing constants (H_FRAME_WIDTH 1280, V_FRAME_HEIGHT 1024, H_MAX 1688, V_MAX 1066), FB_W/FB_H defaults, COLOR_W, the address width and the test-bar colour table from the shared package vga_pkg.
REQ-029 SHALL implement the sideband alignment in one sub-module, vga_delay_line (parameters DEPTH and WIDTH, async active-low clear), instantiated once for {h_sync, v_sync, active, req, frame_start}.

Verification
REQ-030 Scenario: RD_LAT=2, input (h=0,v=0,active=1), memory word 0 = 12'hF00 -> rd_req_o=1 and rd_addr_o=0 one cycle later; rgb_o=12'hF00, active_o=1 and frame_start_o=1 four cycles after the input.
REQ-031 Scenario: input (h=1279,v=1023) -> rd_addr_o=81919; input (h=4,v=4) -> rd_addr_o=321.
REQ-032 Scenario: input (h=1300, active=0) with rd_data_i=12'hFFF -> rd_req_o=0 and rgb_o=0 four cycles later; h_sync_o follows h_sync_i delayed by exactly 4 cycles.
REQ-033 Scenario: free-running counters across the wrap (1687,1065)->(0,0) -> no missing request, and exactly one frame_start_o pulse per 1688*1066 cycles.
REQ-034 Scenario: rst_ni pulsed low mid-line at h=600 -> all outputs 0 immediately; after release the first nonzero rgb_o appears exactly L cycles after the first active input.
REQ-035 Scenario: VGA_TEST_PATTERN_EN defined, test_mode_i=1 -> rd_req_o stays 0; output h=130 gives yellow 12'hFF0, and output h=1000 gives black 12'h000.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, framebuffer defaults, colour-bar table and constant shift-add multiply.
package vga_pkg;
    localparam int H_FRAME_WIDTH  = 1280;
    localparam int V_FRAME_HEIGHT = 1024;
    localparam int H_MAX          = 1688;
    localparam int V_MAX          = 1066;
    localparam int DEF_FB_W       = 320;
    localparam int DEF_FB_H       = 256;
    localparam int DEF_COLOR_W    = 12;
    localparam int ADDR_W         = 17;
    localparam int CNT_W          = 11;

    // index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][11:0] BAR_COLOR = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    function automatic logic [ADDR_W-1:0] mul_const(input logic [ADDR_W-1:0] a, input int k);
        logic [ADDR_W-1:0] s;
        s = '0;
        for (int i = 0; i < ADDR_W; i++)
            if (k[i]) s = s + (a << i);
        return s;
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed DEPTH-stage register delay with asynchronous active-low clear.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: 4x-scaled framebuffer fetch with sideband aligned to the fixed read latency.
// Defining VGA_TEST_PATTERN_EN adds test_mode_i and an 8-bar colour pattern that replaces reads.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter int FB_W    = DEF_FB_W,
    parameter int FB_H    = DEF_FB_H,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic               pixel_clk_i,
    input  logic               rst_ni,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode_i,
`endif
    input  logic [CNT_W-1:0]   h_count_i,
    input  logic [CNT_W-1:0]   v_count_i,
    input  logic               h_sync_i,
    input  logic               v_sync_i,
    input  logic               active_i,
    output logic               rd_req_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    input  logic [COLOR_W-1:0] rd_data_i,
    output logic [COLOR_W-1:0] rgb_o,
    output logic               h_sync_o,
    output logic               v_sync_o,
    output logic               active_o,
    output logic               frame_start_o
);
`ifdef VGA_TEST_PATTERN_EN
    localparam int SB_W = 10;
`else
    localparam int SB_W = 5;
`endif

    logic [8:0]         w_hq, w_vq;
    logic               w_in_fb, w_req, w_fs;
    logic [ADDR_W-1:0]  w_addr, r_addr;
    logic [SB_W-1:0]    w_sb, r_sb, w_dl;
    logic [COLOR_W-1:0] w_fb, w_rgb, r_rgb;
    logic [3:0]         r_out;

    assign w_hq    = h_count_i[CNT_W-1:2];
    assign w_vq    = v_count_i[CNT_W-1:2];
    assign w_in_fb = (int'(w_vq) < FB_H) && (int'(w_hq) < FB_W);
    assign w_addr  = mul_const(ADDR_W'(w_vq), FB_W) + ADDR_W'(w_hq);
    assign w_fs    = (h_count_i == '0) && (v_count_i == '0) && active_i;

    // sideband word: [0] hsync, [1] vsync, [2] active, [3] req, [4] frame start
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] w_bar;
    assign w_req = active_i && w_in_fb && !test_mode_i;
    assign w_sb  = {test_mode_i, h_count_i[10:7], w_fs, w_req, active_i, v_sync_i, h_sync_i};
    assign w_bar = w_dl[8] ? 12'h000 : BAR_COLOR[w_dl[7:5]];
    assign w_rgb = w_dl[9] ? (w_dl[2] ? COLOR_W'(w_bar) : '0) : w_fb;
`else
    assign w_req = active_i && w_in_fb;
    assign w_sb  = {w_fs, w_req, active_i, v_sync_i, h_sync_i};
    assign w_rgb = w_fb;
`endif

    always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sb   <= '0;
            r_addr <= '0;
        end else begin
            r_sb <= w_sb;
            if (w_req) r_addr <= w_addr;
        end
    end

    vga_delay_line #(.DEPTH(RD_LAT), .WIDTH(SB_W)) u_dl (
        .i_clk   (pixel_clk_i),
        .i_rst_n (rst_ni),
        .i_d     (r_sb),
        .o_q     (w_dl)
    );

    assign w_fb = (w_dl[2] && w_dl[3]) ? rd_data_i : '0;

    always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rgb <= '0;
            r_out <= '0;
        end else begin
            r_rgb <= w_rgb;
            r_out <= {w_dl[4], w_dl[2:0]};
        end
    end

    assign rd_req_o      = r_sb[3];
    assign rd_addr_o     = r_addr;
    assign rgb_o         = r_rgb;
    assign h_sync_o      = r_out[0];
    assign v_sync_o      = r_out[1];
    assign active_o      = r_out[2];
    assign frame_start_o = r_out[3];
endmodule
